// File: rtl/pipe_segment_skid.sv
// pipe_segment_skid
// One pipeline segment with a main register and a single skid register. The
// upstream stage can therefore be stalled one edge late without losing the
// entry it was already offering. All state moves on the falling edge of clk,
// like the rest of the pipeline.
module pipe_segment_skid #(
    parameter int DATA_W              = 32,
    parameter int CTRL_W              = 8,
    parameter bit CLEAR_DATA_ON_FLUSH = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        level,
    output logic [15:0]       bubble_cnt
);

    // The state encoding is also the occupancy reported on level.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_nxt;
    logic [CTRL_W-1:0] main_ctrl_p0;
    logic [DATA_W-1:0] main_data_p0;
    logic [CTRL_W-1:0] skid_ctrl_p1;
    logic [DATA_W-1:0] skid_data_p1;
    logic              vld_p0;
    logic              vld_p1;
    logic              ld_main_in;
    logic              ld_main_skid;
    logic              ld_skid_in;

    function automatic logic [15:0] sat_inc16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    assign vld_p0    = (state_q != S_EMPTY);
    assign vld_p1    = (state_q == S_FULL);
    assign in_ready  = !vld_p1;
    assign out_valid = vld_p0;
    assign level     = state_q;
    // A bubble must never present live write enables to the next stage.
    assign out_ctrl  = vld_p0 ? main_ctrl_p0 : '0;
    assign out_data  = main_data_p0;

    // Next-state and register-load decode; flush overrides every transition.
    always_comb begin
        state_nxt    = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid_in   = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (in_valid) begin
                    ld_main_in = 1'b1;
                    state_nxt  = S_ONE;
                end
            end
            S_ONE: begin
                if (in_valid && out_ready) begin
                    ld_main_in = 1'b1;
                end else if (in_valid) begin
                    ld_skid_in = 1'b1;
                    state_nxt  = S_FULL;
                end else if (out_ready) begin
                    state_nxt  = S_EMPTY;
                end
            end
            S_FULL: begin
                if (out_ready) begin
                    ld_main_skid = 1'b1;
                    state_nxt    = S_ONE;
                end
            end
            default: begin
                state_nxt = S_EMPTY;
            end
        endcase
        if (flush) begin
            state_nxt    = S_EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid_in   = 1'b0;
        end
    end

    // Occupancy state register.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Main (_p0) and skid (_p1) payload registers; flush zeroes ctrl, data optionally.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            main_ctrl_p0 <= '0;
            main_data_p0 <= '0;
            skid_ctrl_p1 <= '0;
            skid_data_p1 <= '0;
        end else if (flush) begin
            main_ctrl_p0 <= '0;
            skid_ctrl_p1 <= '0;
            if (CLEAR_DATA_ON_FLUSH) begin
                main_data_p0 <= '0;
                skid_data_p1 <= '0;
            end
        end else begin
            if (ld_main_in) begin
                main_ctrl_p0 <= in_ctrl;
                main_data_p0 <= in_data;
            end else if (ld_main_skid) begin
                main_ctrl_p0 <= skid_ctrl_p1;
                main_data_p0 <= skid_data_p1;
            end
            if (ld_skid_in) begin
                skid_ctrl_p1 <= in_ctrl;
                skid_data_p1 <= in_data;
            end
        end
    end

    // Saturating count of edges with no valid entry on the output; flush does not touch it.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (!vld_p0) begin
            bubble_cnt <= sat_inc16(bubble_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_segment_skid.sv
// Bench for pipe_segment_skid: vector table, hand-written corner sequences and
// randomized traffic against a queue-based reference model.
module tb_pipe_segment_skid;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;

    logic              clk = 1'b1;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;

    logic              in_ready,   in_ready_c;
    logic              out_valid,  out_valid_c;
    logic [CTRL_W-1:0] out_ctrl,   out_ctrl_c;
    logic [DATA_W-1:0] out_data,   out_data_c;
    logic [1:0]        level,      level_c;
    logic [15:0]       bubble_cnt, bubble_cnt_c;

    always #5 clk = ~clk;

    pipe_segment_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA_ON_FLUSH(1'b0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .level(level), .bubble_cnt(bubble_cnt)
    );

    pipe_segment_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA_ON_FLUSH(1'b1)) dut_c (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_ctrl(out_ctrl_c), .out_data(out_data_c),
        .level(level_c), .bubble_cnt(bubble_cnt_c)
    );

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct {
        logic              iv;
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
        logic              ordy;
        logic [1:0]        lvl;
        logic              ov;
        logic              ir;
        logic [CTRL_W-1:0] oc;
        logic [DATA_W-1:0] od;
        logic [15:0]       bub;
    } vec_t;

    // Reference model: an ordered queue of at most two entries.
    ent_t              mq[$];
    logic [DATA_W-1:0] m_data;
    int                m_bub;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_data = '0;
        m_bub  = 0;
    endtask

    task automatic model_step(input logic fl, input logic iv, input logic [CTRL_W-1:0] c,
                              input logic [DATA_W-1:0] d, input logic ordy);
        ent_t e;
        bit   acc;
        if (mq.size() == 0 && m_bub < 65535) m_bub++;
        if (fl) begin
            mq.delete();
        end else begin
            acc = iv && (mq.size() < 2);
            if (ordy && mq.size() > 0) void'(mq.pop_front());
            if (acc) begin
                e.ctrl = c;
                e.data = d;
                mq.push_back(e);
            end
        end
        if (mq.size() > 0) m_data = mq[0].data;
    endtask

    task automatic check_model(input string tag);
        logic [CTRL_W-1:0] ec;
        ec = (mq.size() > 0) ? mq[0].ctrl : '0;
        chk({tag, ".level"},     level,      mq.size());
        chk({tag, ".out_valid"}, out_valid,  mq.size() > 0);
        chk({tag, ".in_ready"},  in_ready,   mq.size() < 2);
        chk({tag, ".out_ctrl"},  out_ctrl,   ec);
        chk({tag, ".out_data"},  out_data,   m_data);
        chk({tag, ".bubble"},    bubble_cnt, m_bub);
        chk({tag, ".c.level"},   level_c,    mq.size());
        chk({tag, ".c.ctrl"},    out_ctrl_c, ec);
        if (mq.size() > 0) chk({tag, ".c.data"}, out_data_c, m_data);
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [CTRL_W-1:0] c,
                         input logic [DATA_W-1:0] d, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic fl, input logic iv, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] d, input logic ordy);
        drive(fl, iv, c, d, ordy);
        model_step(fl, iv, c, d, ordy);
        tick();
        check_model(tag);
    endtask

    vec_t tbl[11];

    initial begin
        // Steady stream, then A/B/C back-pressure and drain.
        tbl[0]  = '{1'b1, 8'h05, 32'h1234, 1'b1, 2'd1, 1'b1, 1'b1, 8'h05, 32'h1234, 16'd1};
        tbl[1]  = '{1'b1, 8'h05, 32'h1235, 1'b1, 2'd1, 1'b1, 1'b1, 8'h05, 32'h1235, 16'd1};
        tbl[2]  = '{1'b1, 8'h05, 32'h1236, 1'b1, 2'd1, 1'b1, 1'b1, 8'h05, 32'h1236, 16'd1};
        tbl[3]  = '{1'b1, 8'h05, 32'h1237, 1'b1, 2'd1, 1'b1, 1'b1, 8'h05, 32'h1237, 16'd1};
        tbl[4]  = '{1'b0, 8'h00, 32'h0,    1'b1, 2'd0, 1'b0, 1'b1, 8'h00, 32'h1237, 16'd1};
        tbl[5]  = '{1'b1, 8'h0A, 32'hAAAA, 1'b0, 2'd1, 1'b1, 1'b1, 8'h0A, 32'hAAAA, 16'd2};
        tbl[6]  = '{1'b1, 8'h0B, 32'hBBBB, 1'b0, 2'd2, 1'b1, 1'b0, 8'h0A, 32'hAAAA, 16'd2};
        tbl[7]  = '{1'b1, 8'h0C, 32'hCCCC, 1'b0, 2'd2, 1'b1, 1'b0, 8'h0A, 32'hAAAA, 16'd2};
        tbl[8]  = '{1'b1, 8'h0C, 32'hCCCC, 1'b1, 2'd1, 1'b1, 1'b1, 8'h0B, 32'hBBBB, 16'd2};
        tbl[9]  = '{1'b1, 8'h0C, 32'hCCCC, 1'b1, 2'd1, 1'b1, 1'b1, 8'h0C, 32'hCCCC, 16'd2};
        tbl[10] = '{1'b0, 8'h00, 32'h0,    1'b1, 2'd0, 1'b0, 1'b1, 8'h00, 32'hCCCC, 16'd2};

        // Reset held across an edge with traffic offered.
        rst = 1'b0;
        drive(1'b0, 1'b1, 8'hFF, 32'hDEAD_BEEF, 1'b1);
        model_reset();
        tick();
        tick();
        chk("rst.level",     level,      2'd0);
        chk("rst.out_valid", out_valid,  1'b0);
        chk("rst.out_ctrl",  out_ctrl,   8'h00);
        chk("rst.out_data",  out_data,   32'h0);
        chk("rst.in_ready",  in_ready,   1'b1);
        chk("rst.bubble",    bubble_cnt, 16'd0);
        @(posedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(1'b0, tbl[i].iv, tbl[i].c, tbl[i].d, tbl[i].ordy);
            model_step(1'b0, tbl[i].iv, tbl[i].c, tbl[i].d, tbl[i].ordy);
            tick();
            chk($sformatf("vec%0d.level", i),     level,      tbl[i].lvl);
            chk($sformatf("vec%0d.out_valid", i), out_valid,  tbl[i].ov);
            chk($sformatf("vec%0d.in_ready", i),  in_ready,   tbl[i].ir);
            chk($sformatf("vec%0d.out_ctrl", i),  out_ctrl,   tbl[i].oc);
            chk($sformatf("vec%0d.out_data", i),  out_data,   tbl[i].od);
            chk($sformatf("vec%0d.bubble", i),    bubble_cnt, tbl[i].bub);
        end

        // Flush while FULL with out_ready and a new offer on the same edge.
        cyc("fl.a", 1'b0, 1'b1, 8'h11, 32'h1111, 1'b0);
        cyc("fl.b", 1'b0, 1'b1, 8'h22, 32'h2222, 1'b0);
        chk("fl.full", level, 2'd2);
        cyc("fl.edge", 1'b1, 1'b1, 8'h33, 32'h3333, 1'b1);
        chk("fl.level",     level,      2'd0);
        chk("fl.out_valid", out_valid,  1'b0);
        chk("fl.out_ctrl",  out_ctrl,   8'h00);
        chk("fl.out_data",  out_data,   32'h1111);
        chk("fl.c.data",    out_data_c, 32'h0);
        cyc("fl.after0", 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
        chk("fl.noskid", out_valid, 1'b0);
        cyc("fl.after1", 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);

        // Asynchronous reset between edges while FULL.
        cyc("ar.a", 1'b0, 1'b1, 8'h44, 32'h4444, 1'b0);
        cyc("ar.b", 1'b0, 1'b1, 8'h55, 32'h5555, 1'b0);
        chk("ar.full", level, 2'd2);
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar.level",     level,      2'd0);
        chk("ar.out_valid", out_valid,  1'b0);
        chk("ar.out_ctrl",  out_ctrl,   8'h00);
        chk("ar.out_data",  out_data,   32'h0);
        chk("ar.in_ready",  in_ready,   1'b1);
        chk("ar.bubble",    bubble_cnt, 16'd0);
        rst = 1'b1;
        model_reset();
        cyc("ar.d", 1'b0, 1'b1, 8'h66, 32'hD0D0, 1'b1);
        chk("ar.d.data", out_data, 32'hD0D0);
        cyc("ar.drain", 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
        chk("ar.nostale", out_valid, 1'b0);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 500; i++) begin
            cyc($sformatf("rnd%0d", i),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 9) < 7),
                CTRL_W'($urandom),
                $urandom,
                ($urandom_range(0, 9) < 6));
        end

        // Bubble counter saturation over a long idle stretch.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 70000; i++) begin
            drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
            model_step(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
            tick();
            if (i == 65533) chk("sat.fffe", bubble_cnt, 16'hFFFE);
            if (i == 65534) chk("sat.ffff", bubble_cnt, 16'hFFFF);
        end
        chk("sat.hold",   bubble_cnt,   16'hFFFF);
        chk("sat.c.hold", bubble_cnt_c, 16'hFFFF);
        check_model("sat.end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
